// File: rtl/icache_direct_if.sv
// Bus bundle between icache_direct, the IF stage and mem_ctrl.
// The slave modport is the cache side; the master modport is the IF/mem_ctrl environment.
interface icache_direct_if #(
    parameter int ADDR_W = 32
);
    logic              if_inst_read_in;
    logic [ADDR_W-1:0] if_inst_address_in;
    logic              flush_in;
    logic              icache_inst_enable_out;
    logic [31:0]       icache_inst_data_out;
    logic              icache_inst_read_out;
    logic [ADDR_W-1:0] icache_inst_address_out;
    logic              mc_inst_enable;
    logic [31:0]       mc_inst_data;

    modport slave (
        input  if_inst_read_in, if_inst_address_in, flush_in,
        input  mc_inst_enable, mc_inst_data,
        output icache_inst_enable_out, icache_inst_data_out,
        output icache_inst_read_out, icache_inst_address_out
    );

    modport master (
        output if_inst_read_in, if_inst_address_in, flush_in,
        output mc_inst_enable, mc_inst_data,
        input  icache_inst_enable_out, icache_inst_data_out,
        input  icache_inst_read_out, icache_inst_address_out
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Hits answer in one cycle; misses fetch a single word from mem_ctrl and fill the line.
module icache_direct #(
    parameter int INDEX_W = 8,
    parameter int ADDR_W  = 32
) (
    input logic              clk_in,
    input logic              rst_in,
    input logic              rdy_in,
    icache_direct_if.slave   bus
);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t             state;
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [31:0]        data_mem [ENTRIES];
    logic               drop;

    logic               enable_q;
    logic [31:0]        data_q;
    logic               read_q;
    logic [ADDR_W-1:0]  address_q;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic               hit;
    logic               unused_addr_lo;

    assign req_idx        = bus.if_inst_address_in[INDEX_W+1:2];
    assign req_tag        = bus.if_inst_address_in[ADDR_W-1:INDEX_W+2];
    assign miss_idx       = address_q[INDEX_W+1:2];
    assign miss_tag       = address_q[ADDR_W-1:INDEX_W+2];
    assign hit            = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_addr_lo = ^bus.if_inst_address_in[1:0];

    assign bus.icache_inst_enable_out  = enable_q;
    assign bus.icache_inst_data_out    = data_q;
    assign bus.icache_inst_read_out    = read_q;
    assign bus.icache_inst_address_out = address_q;

    // Line storage carries no reset; the valid bits alone decide whether it is meaningful.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && state == MISS && bus.mc_inst_enable) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= bus.mc_inst_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            valid     <= '0;
            drop      <= 1'b0;
            enable_q  <= 1'b0;
            data_q    <= '0;
            read_q    <= 1'b0;
            address_q <= '0;
        end else if (rdy_in) begin
            enable_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_inst_read_in && !bus.flush_in) begin
                        if (hit) begin
                            enable_q <= 1'b1;
                            data_q   <= data_mem[req_idx];
                        end else begin
                            state     <= MISS;
                            read_q    <= 1'b1;
                            address_q <= {bus.if_inst_address_in[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                MISS: begin
                    // A flushed miss still fills the line; it just never answers IF.
                    if (bus.mc_inst_enable) begin
                        valid[miss_idx] <= 1'b1;
                        read_q          <= 1'b0;
                        state           <= IDLE;
                        drop            <= 1'b0;
                        if (!drop && !bus.flush_in) begin
                            enable_q <= 1'b1;
                            data_q   <= bus.mc_inst_data;
                        end
                    end else if (bus.flush_in) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: a scoreboard queue holds each expected response word
// together with the cycle it must appear in; a negedge monitor pops and checks every pulse.
module tb_icache_direct;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    icache_direct_if #(.ADDR_W(32)) bus ();

    icache_direct #(.INDEX_W(8), .ADDR_W(32)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then returns 2 time units after the sampling edge.
    task automatic applyStimulus(input logic rd, input logic [31:0] addr, input logic fl,
                                 input logic mce, input logic [31:0] mcd);
        bus.if_inst_read_in    = rd;
        bus.if_inst_address_in = addr;
        bus.flush_in           = fl;
        bus.mc_inst_enable     = mce;
        bus.mc_inst_data       = mcd;
        @(posedge clk);
        #2;
    endtask

    task automatic pushExp(input logic [31:0] data);
        exp_t e;
        e.data = data;
        e.cyc  = cyc_cnt + 1;
        sb.push_back(e);
    endtask

    task automatic checkMiss(input string tag, input logic [31:0] addr);
        checkOutput({tag, "_read"}, {31'd0, bus.icache_inst_read_out}, 32'd1);
        checkOutput({tag, "_addr"}, bus.icache_inst_address_out, addr);
    endtask

    always @(negedge clk) begin
        if (bus.icache_inst_enable_out === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("resp_data", bus.icache_inst_data_out, e.data);
                checkOutput("resp_cycle", cyc_cnt, e.cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_enable", {31'd0, bus.icache_inst_enable_out}, 32'd0);
        checkOutput("rst_data", bus.icache_inst_data_out, 32'd0);
        checkOutput("rst_read", {31'd0, bus.icache_inst_read_out}, 32'd0);
        checkOutput("rst_addr", bus.icache_inst_address_out, 32'd0);
        rst_n = 1'b1;

        // Cold miss then fill
        applyStimulus(1, 32'h4, 0, 0, 0);
        checkMiss("cold", 32'h4);
        applyStimulus(1, 32'h4, 0, 0, 0);
        checkOutput("cold_hold", {31'd0, bus.icache_inst_read_out}, 32'd1);
        pushExp(32'h00500093);
        applyStimulus(1, 32'h4, 0, 1, 32'h00500093);
        checkOutput("cold_read_clr", {31'd0, bus.icache_inst_read_out}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0);

        // Hit after fill, then back-to-back hits on 0x4 and 0x8
        pushExp(32'h00500093);
        applyStimulus(1, 32'h4, 0, 0, 0);
        checkOutput("hit_no_read", {31'd0, bus.icache_inst_read_out}, 32'd0);
        applyStimulus(1, 32'h8, 0, 0, 0);
        checkMiss("fill8", 32'h8);
        pushExp(32'h11111111);
        applyStimulus(1, 32'h8, 0, 1, 32'h11111111);
        pushExp(32'h00500093);
        applyStimulus(1, 32'h4, 0, 0, 0);
        pushExp(32'h11111111);
        applyStimulus(1, 32'h8, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Conflict eviction on index 4
        applyStimulus(1, 32'h10, 0, 0, 0);
        checkMiss("c10", 32'h10);
        pushExp(32'h22222222);
        applyStimulus(1, 32'h10, 0, 1, 32'h22222222);
        applyStimulus(1, 32'h410, 0, 0, 0);
        checkMiss("c410", 32'h410);
        pushExp(32'h33333333);
        applyStimulus(1, 32'h410, 0, 1, 32'h33333333);
        applyStimulus(1, 32'h10, 0, 0, 0);
        checkMiss("c10_again", 32'h10);
        pushExp(32'h22222222);
        applyStimulus(1, 32'h10, 0, 1, 32'h22222222);
        applyStimulus(0, 0, 0, 0, 0);

        // Flush in IDLE ignores a missing request
        applyStimulus(1, 32'h20, 1, 0, 0);
        checkOutput("idle_flush_read", {31'd0, bus.icache_inst_read_out}, 32'd0);

        // Flush during miss: fill happens, no response
        applyStimulus(1, 32'h20, 0, 0, 0);
        checkMiss("f20", 32'h20);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h44444444);
        checkOutput("flush_read_clr", {31'd0, bus.icache_inst_read_out}, 32'd0);
        checkOutput("flush_no_pulse", {31'd0, bus.icache_inst_enable_out}, 32'd0);
        pushExp(32'h44444444);
        applyStimulus(1, 32'h20, 0, 0, 0);
        checkOutput("f20_hit_no_read", {31'd0, bus.icache_inst_read_out}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0);

        // rdy stall mid-miss; an mc pulse during the stall is ignored
        applyStimulus(1, 32'h30, 0, 0, 0);
        checkMiss("s30", 32'h30);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h34, 1'(i == 1), 1'(i == 2), 32'hdeadbeef);
            checkMiss("stall", 32'h30);
        end
        rdy = 1'b1;
        applyStimulus(1, 32'h30, 0, 0, 0);
        checkMiss("stall_after", 32'h30);
        pushExp(32'h55555555);
        applyStimulus(1, 32'h30, 0, 1, 32'h55555555);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset mid-miss
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkMiss("r40", 32'h40);
        rst_n = 1'b0;
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkOutput("mrst_enable", {31'd0, bus.icache_inst_enable_out}, 32'd0);
        checkOutput("mrst_data", bus.icache_inst_data_out, 32'd0);
        checkOutput("mrst_read", {31'd0, bus.icache_inst_read_out}, 32'd0);
        checkOutput("mrst_addr", bus.icache_inst_address_out, 32'd0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 32'h66666666);
        checkOutput("stray_no_pulse", {31'd0, bus.icache_inst_enable_out}, 32'd0);
        applyStimulus(1, 32'h4, 0, 0, 0);
        checkMiss("post_rst_4", 32'h4);
        pushExp(32'h77777777);
        applyStimulus(1, 32'h4, 0, 1, 32'h77777777);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the IF stage (upstream requester) and mem_ctrl (downstream word fetcher).
- Serves hits from a tag/data array in one cycle.
- On a miss, issues a single-word fetch to mem_ctrl, fills the line, then returns the instruction to IF.
- One line = one 32-bit instruction word; no prefetch, no writes.

Parameters:
- INDEX_W, 8, index bits; ENTRIES = 2^INDEX_W lines.
- ADDR_W, 32, instruction address width.
- TAG_W, ADDR_W-INDEX_W-2, tag bits = addr[ADDR_W-1 : INDEX_W+2].

Ports:
- clk_in  input  1  single system clock, rising edge.
- rst_in  input  1  synchronous, active-low reset: sampled on clk_in rising edge; 0 = reset.
- rdy_in  input  1  global ready; 0 freezes all state and outputs.
- if_inst_read_in  input  1  IF fetch request (level); held with a stable address until the response pulse.
- if_inst_address_in  input  ADDR_W  fetch PC; bits [1:0] ignored.
- flush_in  input  1  pipeline redirect; cancels any outstanding request.
- icache_inst_enable_out  output  1  one-cycle pulse: instruction valid.
- icache_inst_data_out  output  32  instruction word; meaningful only with the enable pulse.
- icache_inst_read_out  output  1  miss fetch request to mem_ctrl (level).
- icache_inst_address_out  output  ADDR_W  word-aligned miss address ({addr[ADDR_W-1:2],2'b00}).
- mc_inst_enable  input  1  mem_ctrl one-cycle pulse: fetched word valid.
- mc_inst_data  input  32  fetched word.

Behaviour:
- Reset (rst_in=0 at edge):
  - All valid bits cleared; state=IDLE; drop flag cleared.
  - icache_inst_enable_out=0, icache_inst_data_out=0, icache_inst_read_out=0, icache_inst_address_out=0.
  - Reset mid-miss abandons the fetch; any mem_ctrl pulse arriving afterwards in IDLE is ignored.
- rdy_in=0 (with rst_in=1): no register changes; outputs hold their values. Inputs sampled that cycle are ignored.
- Output pulse rule: enable_out is registered and deasserts the cycle after it rises unless another response is produced.
- IDLE:
  - if_inst_read_in=1, flush_in=0, valid[idx] and tag match (hit): next cycle enable_out=1 with data[idx]. Back-to-back hits give one per cycle.
  - The request whose response pulse is being driven this cycle is not re-served, i.e. IF drops or changes the request in the pulse cycle. The bench must model IF this way.
  - Miss: go to MISS; latch the aligned address into icache_inst_address_out; assert icache_inst_read_out next cycle.
  - flush_in=1 in IDLE: request ignored; no response.
- MISS:
  - icache_inst_read_out held 1 until mc_inst_enable=1.
  - On mc_inst_enable: write data[idx]=mc_inst_data, tag[idx], valid[idx]=1 (always fills, even if dropped); read_out=0; state=IDLE.
  - On the same edge, enable_out=1 with mc_inst_data unless drop is set or flush_in=1 in that cycle.
  - flush_in=1 at any cycle in MISS sets drop. The fetch completes and fills but produces no response. drop clears on return to IDLE.
  - if_inst_read_in/address changes during MISS are ignored; the miss always uses the latched address.
- Miss latency: request edge T → read_out at T+1 → response at (mem_ctrl pulse edge)+1.
- Replacement: direct-mapped overwrite; a conflicting tag evicts silently.
- No self-modifying-code coherence; valid bits clear only on reset.

Test Plan:
- Cold miss: reset, then request 0x00000004. Expect read_out=1 with address 0x4 one cycle later. mc pulse with 0x00500093 → enable_out=1, data=0x00500093 on the next cycle; read_out=0.
- Hit after fill: re-request 0x00000004 → enable_out=1, data=0x00500093 exactly one cycle after the request; read_out stays 0. Then 0x4 and 0x8 on consecutive cycles, with 0x8 pre-filled → two consecutive pulses.
- Conflict eviction (INDEX_W=8): fill 0x00000010, then request 0x00000410 (same index) → miss with read_out address 0x410. After fill, 0x10 misses again.
- Flush during miss: miss on 0x20, assert flush_in for one cycle before the mc pulse → no enable_out pulse. A later request to 0x20 hits in one cycle.
- rdy_in stall: during MISS drive rdy_in=0 for 3 cycles → read_out, address and state unchanged. Fetch completes normally after rdy_in=1.
- Reset mid-miss: rst_in=0 while read_out=1 → next cycle all outputs 0. A prior-filled address now misses. A stray mc pulse in IDLE produces no output.
